// File: rtl/bell_game_ctrl.sv
// Round controller for the two-player bell card game: deals cards, arbitrates bells, scores and detects a winner.
// Optional macro BELL_LOCKOUT_EN locks out a wrong-belling player until the next completed deal.
module bell_game_ctrl #(
    parameter int unsigned DEAL_TICKS = 1000,
    parameter int unsigned WIN_MARGIN = 50,
    parameter int unsigned PENALTY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  keypad_in,
    input  logic        key_valid,
    output logic        card_req,
    input  logic        card_ack,
    input  logic [1:0]  card_c,
    input  logic [2:0]  card_n,
    output logic [1:0]  c1,
    output logic [1:0]  c2,
    output logic [2:0]  n1,
    output logic [2:0]  n2,
    output logic [6:0]  pile_count,
    output logic [15:0] add_score,
    output logic        add_valid,
    input  logic [17:0] total_score,
    output logic [1:0]  winner,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEAL   = 3'd1,
        S_WAIT   = 3'd2,
        S_JUDGE  = 3'd3,
        S_AWARD  = 3'd4,
        S_SETTLE = 3'd5,
        S_CHECK  = 3'd6,
        S_OVER   = 3'd7
    } state_t;

    localparam logic [3:0]         KEY_A     = 4'b0111;
    localparam logic [3:0]         KEY_B     = 4'b1001;
    localparam logic [15:0]        LP_TICKS  = 16'(DEAL_TICKS);
    localparam logic [7:0]         LP_PEN    = 8'(PENALTY);
    localparam logic signed [9:0]  LP_MARGIN = 10'(WIN_MARGIN);

    state_t       r_state;
    logic         r_turnB;
    logic         r_presserB;
    logic [15:0]  r_timer;
    logic         r_validA;
    logic         r_validB;
    logic [1:0]   r_c1;
    logic [1:0]   r_c2;
    logic [2:0]   r_n1;
    logic [2:0]   r_n2;
    logic [6:0]   r_pile;
    logic [15:0]  r_addScore;
    logic         r_addValid;
    logic [1:0]   r_winner;
    logic         r_cardReq;

    logic         w_bellA;
    logic         w_bellB;
    logic         w_bell;
    logic [3:0]   w_sum;
    logic         w_right;
    logic [7:0]   w_pileDelta;
    logic [7:0]   w_negPen;
    logic signed [9:0] w_sA;
    logic signed [9:0] w_sB;
    logic signed [9:0] w_diffAB;
    logic signed [9:0] w_diffBA;

`ifdef BELL_LOCKOUT_EN
    logic r_lockA;
    logic r_lockB;
    assign w_bellA = key_valid && (keypad_in == KEY_A) && !r_lockA;
    assign w_bellB = key_valid && (keypad_in == KEY_B) && !r_lockB;
`else
    assign w_bellA = key_valid && (keypad_in == KEY_A);
    assign w_bellB = key_valid && (keypad_in == KEY_B);
`endif

    assign w_bell      = w_bellA || w_bellB;
    assign w_sum       = {1'b0, r_n1} + {1'b0, r_n2};
    assign w_right     = r_validA && r_validB &&
                         ((r_c1 == r_c2) ? (w_sum == 4'd5) : ((r_n1 == 3'd5) || (r_n2 == 3'd5)));
    assign w_pileDelta = {1'b0, r_pile};
    assign w_negPen    = ~LP_PEN + 8'd1;
    assign w_sA        = {total_score[8], total_score[8:0]};
    assign w_sB        = {total_score[17], total_score[17:9]};
    assign w_diffAB    = w_sA - w_sB;
    assign w_diffBA    = w_sB - w_sA;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_turnB    <= 1'b0;
            r_presserB <= 1'b0;
            r_timer    <= 16'd0;
            r_validA   <= 1'b0;
            r_validB   <= 1'b0;
            r_c1       <= 2'd0;
            r_c2       <= 2'd0;
            r_n1       <= 3'd0;
            r_n2       <= 3'd0;
            r_pile     <= 7'd0;
            r_addScore <= 16'd0;
            r_addValid <= 1'b0;
            r_winner   <= 2'b00;
            r_cardReq  <= 1'b0;
`ifdef BELL_LOCKOUT_EN
            r_lockA    <= 1'b0;
            r_lockB    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_DEAL;
                        r_turnB <= 1'b0;
                    end
                end
                // An ack is only honoured once our request is actually visible to the deck.
                S_DEAL: begin
                    if (r_cardReq && card_ack) begin
                        r_cardReq <= 1'b0;
                        if (!r_turnB) begin
                            r_c1     <= card_c;
                            r_n1     <= card_n;
                            r_validA <= 1'b1;
                        end else begin
                            r_c2     <= card_c;
                            r_n2     <= card_n;
                            r_validB <= 1'b1;
                        end
                        if (r_pile != 7'd127) begin
                            r_pile <= r_pile + 7'd1;
                        end
                        r_turnB <= ~r_turnB;
                        r_timer <= LP_TICKS;
                        r_state <= S_WAIT;
`ifdef BELL_LOCKOUT_EN
                        r_lockA <= 1'b0;
                        r_lockB <= 1'b0;
`endif
                    end else begin
                        r_cardReq <= 1'b1;
                    end
                end
                // A bell takes priority over an expiring timer in the same cycle.
                S_WAIT: begin
                    if (w_bell) begin
                        r_presserB <= w_bellB;
                        r_state    <= S_JUDGE;
                    end else if (r_timer <= 16'd1) begin
                        r_state <= S_DEAL;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_JUDGE: begin
                    r_addValid <= 1'b1;
                    r_state    <= S_AWARD;
                    if (w_right) begin
                        r_addScore <= r_presserB ? {w_pileDelta, 8'h00} : {8'h00, w_pileDelta};
                        r_validA   <= 1'b0;
                        r_validB   <= 1'b0;
                        r_c1       <= 2'd0;
                        r_c2       <= 2'd0;
                        r_n1       <= 3'd0;
                        r_n2       <= 3'd0;
                        r_pile     <= 7'd0;
                    end else begin
                        r_addScore <= r_presserB ? {w_negPen, LP_PEN} : {LP_PEN, w_negPen};
`ifdef BELL_LOCKOUT_EN
                        if (r_presserB) begin
                            r_lockB <= 1'b1;
                        end else begin
                            r_lockA <= 1'b1;
                        end
`endif
                    end
                end
                S_AWARD: begin
                    r_addValid <= 1'b0;
                    r_addScore <= 16'd0;
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_diffAB > LP_MARGIN) begin
                        r_winner <= 2'b01;
                        r_state  <= S_OVER;
                    end else if (w_diffBA > LP_MARGIN) begin
                        r_winner <= 2'b10;
                        r_state  <= S_OVER;
                    end else begin
                        r_timer <= LP_TICKS;
                        r_state <= S_WAIT;
                    end
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign card_req   = r_cardReq;
    assign c1         = r_c1;
    assign c2         = r_c2;
    assign n1         = r_n1;
    assign n2         = r_n2;
    assign pile_count = r_pile;
    assign add_score  = r_addScore;
    assign add_valid  = r_addValid;
    assign winner     = r_winner;
    assign state      = r_state;

endmodule

// File: tb/tb_bell_game_ctrl.sv
// Directed self-checking bench for bell_game_ctrl; expected values are hand-computed from the game rules.
module tb_bell_game_ctrl;

    localparam logic [3:0] KEY_A = 4'b0111;
    localparam logic [3:0] KEY_B = 4'b1001;
    localparam int TICKS = 20;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  keypad_in;
    logic        key_valid;
    logic        card_req;
    logic        card_ack;
    logic [1:0]  card_c;
    logic [2:0]  card_n;
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic [2:0]  n1;
    logic [2:0]  n2;
    logic [6:0]  pile_count;
    logic [15:0] add_score;
    logic        add_valid;
    logic [17:0] total_score;
    logic [1:0]  winner;
    logic [2:0]  state;

    int checkCount;
    int failCount;

    bell_game_ctrl #(
        .DEAL_TICKS(TICKS),
        .WIN_MARGIN(50),
        .PENALTY(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .keypad_in(keypad_in),
        .key_valid(key_valid),
        .card_req(card_req),
        .card_ack(card_ack),
        .card_c(card_c),
        .card_n(card_n),
        .c1(c1),
        .c2(c2),
        .n1(n1),
        .n2(n2),
        .pile_count(pile_count),
        .add_score(add_score),
        .add_valid(add_valid),
        .total_score(total_score),
        .winner(winner),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        rst         = 1'b0;
        start       = 1'b0;
        key_valid   = 1'b0;
        keypad_in   = 4'd0;
        card_ack    = 1'b0;
        card_c      = 2'd0;
        card_n      = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for the deck request, then serves one card.
    task automatic applyDeal(input logic [1:0] c, input logic [2:0] n, input string tag);
        for (int i = 0; i < 3 * TICKS && card_req !== 1'b1; i++) begin
            @(negedge clk);
        end
        checkOutput({tag, "_reqRise"}, 32'(card_req), 32'd1);
        card_c   = c;
        card_n   = n;
        card_ack = 1'b1;
        @(negedge clk);
        card_ack = 1'b0;
        checkOutput({tag, "_toWait"}, 32'(state), 32'd2);
        checkOutput({tag, "_reqDrop"}, 32'(card_req), 32'd0);
    endtask

    // Rings a bell after waitCycles and follows it through judge/award/settle/check.
    task automatic applyBell(input logic [3:0] code, input logic [15:0] expScore,
                             input logic [2:0] expNext, input int waitCycles, input string tag);
        repeat (waitCycles) @(negedge clk);
        keypad_in = code;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        keypad_in = 4'd0;
        checkOutput({tag, "_judge"}, 32'(state), 32'd3);
        checkOutput({tag, "_noReq"}, 32'(card_req), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_awardValid"}, 32'(add_valid), 32'd1);
        checkOutput({tag, "_awardScore"}, 32'(add_score), 32'(expScore));
        @(negedge clk);
        checkOutput({tag, "_settleValid"}, 32'(add_valid), 32'd0);
        checkOutput({tag, "_settleScore"}, 32'(add_score), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_check"}, 32'(state), 32'd6);
        @(negedge clk);
        checkOutput({tag, "_next"}, 32'(state), 32'(expNext));
    endtask

    initial begin
        int stuckLow;
        checkCount  = 0;
        failCount   = 0;
        total_score = 18'd0;
        applyReset();

        checkOutput("rstState", 32'(state), 32'd0);
        checkOutput("rstReq", 32'(card_req), 32'd0);
        checkOutput("rstValid", 32'(add_valid), 32'd0);
        checkOutput("rstScore", 32'(add_score), 32'd0);
        checkOutput("rstWinner", 32'(winner), 32'd0);
        checkOutput("rstPile", 32'(pile_count), 32'd0);
        checkOutput("rstCards", 32'({c1, c2, n1, n2}), 32'd0);

        // Right bell, same colour summing to five.
        applyStart();
        checkOutput("startDeal", 32'(state), 32'd1);
        applyDeal(2'd0, 3'd2, "deal1");
        checkOutput("deal1Card", 32'({c1, n1}), 32'({2'd0, 3'd2}));
        checkOutput("deal1Pile", 32'(pile_count), 32'd1);
        applyDeal(2'd0, 3'd3, "deal2");
        checkOutput("deal2Card", 32'({c2, n2}), 32'({2'd0, 3'd3}));
        checkOutput("deal2Pile", 32'(pile_count), 32'd2);
        applyBell(KEY_A, 16'h0002, 3'd2, 0, "bellA1");
        checkOutput("bellA1Pile", 32'(pile_count), 32'd0);
        checkOutput("bellA1Slots", 32'({c1, c2, n1, n2}), 32'd0);

        // Right bell, different colours with a five showing.
        applyDeal(2'd1, 3'd5, "deal3");
        applyDeal(2'd2, 3'd1, "deal4");
        applyBell(KEY_B, 16'h0200, 3'd2, 0, "bellB1");
        checkOutput("bellB1Slots", 32'({c1, c2, n1, n2}), 32'd0);

        // Wrong bell leaves pile and slots alone.
        applyDeal(2'd0, 3'd1, "deal5");
        applyDeal(2'd0, 3'd1, "deal6");
        applyBell(KEY_A, 16'h01FF, 3'd2, 0, "wrongA");
        checkOutput("wrongAPile", 32'(pile_count), 32'd2);
        checkOutput("wrongASlot", 32'({n1, n2}), 32'({3'd1, 3'd1}));

        keypad_in = 4'b0101;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        keypad_in = 4'd0;
        checkOutput("badCodeIgnored", 32'(state), 32'd2);
`ifdef BELL_LOCKOUT_EN
        keypad_in = KEY_A;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        keypad_in = 4'd0;
        checkOutput("lockoutA", 32'(state), 32'd2);
`endif

        // Timer-driven deal overwrites A; A=(0,4) with B=(0,1) is now right.
        applyDeal(2'd0, 3'd4, "deal7");
        checkOutput("deal7Pile", 32'(pile_count), 32'd3);
        applyBell(KEY_B, 16'h0300, 3'd2, 0, "bellB2");
        checkOutput("bellB2Pile", 32'(pile_count), 32'd0);

        // Only one slot valid: any bell is wrong even with a five.
        applyDeal(2'd3, 3'd5, "deal8");
        applyBell(KEY_A, 16'h01FF, 3'd2, 0, "oneSlot");
        checkOutput("oneSlotPile", 32'(pile_count), 32'd1);

        // Bell lands in the same cycle the timer would expire.
        applyBell(KEY_B, 16'hFF01, 3'd2, TICKS - 1, "expiryBell");

        // Lead of exactly the margin does not win.
        applyDeal(2'd1, 3'd2, "deal9");
        total_score = {9'd0, 9'd50};
        applyBell(KEY_A, 16'h0002, 3'd2, 0, "marginEq");
        checkOutput("marginEqWinner", 32'(winner), 32'd0);

        // Lead one beyond the margin ends the game for A.
        total_score = {9'd0, 9'd51};
        applyBell(KEY_B, 16'hFF01, 3'd7, 0, "winA");
        checkOutput("winAWinner", 32'(winner), 32'd1);

        start     = 1'b1;
        keypad_in = KEY_A;
        key_valid = 1'b1;
        repeat (2) @(negedge clk);
        start     = 1'b0;
        key_valid = 1'b0;
        keypad_in = 4'd0;
        @(negedge clk);
        checkOutput("overState", 32'(state), 32'd7);
        checkOutput("overWinner", 32'(winner), 32'd1);
        checkOutput("overValid", 32'(add_valid), 32'd0);

        // Stalled deck handshake, stray ack, then reset mid-handshake.
        total_score = 18'd0;
        applyReset();
        checkOutput("rst2Winner", 32'(winner), 32'd0);
        applyStart();
        card_c   = 2'd2;
        card_n   = 3'd7;
        card_ack = 1'b1;
        @(negedge clk);
        card_ack = 1'b0;
        checkOutput("strayAckState", 32'(state), 32'd1);
        checkOutput("strayAckCard", 32'({c1, n1}), 32'd0);
        stuckLow = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (card_req !== 1'b1) stuckLow++;
        end
        checkOutput("holdReqLowCycles", 32'(stuckLow), 32'd0);
        checkOutput("holdState", 32'(state), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("asyncRstReq", 32'(card_req), 32'd0);
        checkOutput("asyncRstState", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // B wins with a large lead after a wrong bell.
        applyStart();
        applyDeal(2'd0, 3'd5, "deal10");
        total_score = {9'd60, 9'd0};
        applyBell(KEY_B, 16'hFF01, 3'd7, 0, "winB");
        checkOutput("winBWinner", 32'(winner), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
